ref_force_wb_arbiter: RTL and testbench

// Sits directly downstream of the NUM_ACC per-cell reference-particle force accumulators.

---
 rtl/ref_force_wb_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ref_force_wb_arbiter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ref_force_wb_arbiter.sv
// rtl/ref_force_wb_arbiter.sv - per-lane force FIFOs serialised round-robin onto one writeback port
module ref_force_wb_arbiter #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 20,
  parameter int CELL_ID_WIDTH     = 3,
  parameter int ID_WIDTH          = 3*CELL_ID_WIDTH+PARTICLE_ID_WIDTH,
  parameter int NUM_ACC           = 7,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_ACC-1:0]            in_valid,
  input  logic [NUM_ACC-1:0]            in_start_wb,
  input  logic [NUM_ACC*ID_WIDTH-1:0]   in_id,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] in_force_x,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] in_force_y,
  input  logic [NUM_ACC*DATA_WIDTH-1:0] in_force_z,
  output logic                          out_wb_valid,
  input  logic                          out_wb_ready,
  output logic [2:0]                    out_wb_lane,
  output logic [ID_WIDTH-1:0]           out_wb_id,
  output logic [DATA_WIDTH-1:0]         out_wb_force_x,
  output logic [DATA_WIDTH-1:0]         out_wb_force_y,
  output logic [DATA_WIDTH-1:0]         out_wb_force_z,
  output logic                          out_wb_done,
  output logic [NUM_ACC-1:0]            out_overflow
);

  localparam int LW = 3;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ID_WIDTH + 3*DATA_WIDTH;
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_ACC-1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef logic [EW-1:0] entry_t;

  // Lane FIFO storage and bookkeeping
  entry_t        mem    [NUM_ACC][FIFO_DEPTH];
  logic [PW-1:0] wr_ptr [NUM_ACC];
  logic [PW-1:0] rd_ptr [NUM_ACC];
  logic [CW-1:0] cnt    [NUM_ACC];
  entry_t        in_entry [NUM_ACC];

  logic [NUM_ACC-1:0] non_empty;
  logic [NUM_ACC-1:0] full;
  logic [NUM_ACC-1:0] pop;
  logic [NUM_ACC-1:0] push_ok;
  logic [NUM_ACC-1:0] drop;

  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] grant;
  logic          grant_found;
  logic          load;
  entry_t        head;

  logic start_prev;
  logic start_rise;
  logic wb_pending;
  logic done_cond;

  // Unpack lane inputs into FIFO entries and derive per-lane status
  always_comb begin
    for (int i = 0; i < NUM_ACC; i++) begin
      in_entry[i]  = {in_id[i*ID_WIDTH +: ID_WIDTH],
                      in_force_x[i*DATA_WIDTH +: DATA_WIDTH],
                      in_force_y[i*DATA_WIDTH +: DATA_WIDTH],
                      in_force_z[i*DATA_WIDTH +: DATA_WIDTH]};
      non_empty[i] = (cnt[i] != '0);
      full[i]      = (cnt[i] == FULL_CNT);
    end
  end

  // Round-robin grant: first non-empty lane at or after rr_ptr
  always_comb begin
    int            idx;
    logic [LW-1:0] cand;
    grant_found = 1'b0;
    grant       = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < NUM_ACC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_ACC) idx = idx - NUM_ACC;
      cand = idx[LW-1:0];
      if (!grant_found && non_empty[cand]) begin
        grant_found = 1'b1;
        grant       = cand;
      end
    end
  end

  // Output register may take a new word when empty or when its word is being accepted
  always_comb begin
    load = ~out_wb_valid | out_wb_ready;
    pop  = '0;
    if (load && grant_found) pop[grant] = 1'b1;
    push_ok = in_valid & (~full | pop);
    drop    = in_valid & full & ~pop;
    head    = mem[grant][rd_ptr[grant]];
  end

  // FIFO payload write; storage needs no reset since counts gate every read
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ACC; i++) begin
      if (push_ok[i]) mem[i][wr_ptr[i]] <= in_entry[i];
    end
  end

  // FIFO pointers and occupancy; a full FIFO popped this cycle still accepts a push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ACC; i++) begin
        if (push_ok[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])     rd_ptr[i] <= rd_ptr[i] + 1'b1;
        case ({push_ok[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Sticky drop flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_overflow <= '0;
    else        out_overflow <= out_overflow | drop;
  end

  // Output word register and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_wb_valid   <= 1'b0;
      out_wb_lane    <= '0;
      out_wb_id      <= '0;
      out_wb_force_x <= '0;
      out_wb_force_y <= '0;
      out_wb_force_z <= '0;
      rr_ptr         <= '0;
    end else if (load) begin
      if (grant_found) begin
        out_wb_valid <= 1'b1;
        out_wb_lane  <= grant;
        {out_wb_id, out_wb_force_x, out_wb_force_y, out_wb_force_z} <= head;
        rr_ptr       <= (grant == LAST_LANE) ? '0 : grant + 1'b1;
      end else begin
        out_wb_valid <= 1'b0;
      end
    end
  end

  // Round completion: armed by a start edge, fires once everything has drained
  always_comb begin
    start_rise = (|in_start_wb) & ~start_prev;
    done_cond  = wb_pending & ~(|non_empty) & ~out_wb_valid & ~(|in_valid);
  end

  // Done pulse and pending flag; a coincident start edge keeps the round armed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_prev  <= 1'b0;
      wb_pending  <= 1'b0;
      out_wb_done <= 1'b0;
    end else begin
      start_prev  <= |in_start_wb;
      wb_pending  <= start_rise | (wb_pending & ~done_cond);
      out_wb_done <= done_cond;
    end
  end

endmodule

// File: tb/tb_ref_force_wb_arbiter.sv
// tb/tb_ref_force_wb_arbiter.sv - scoreboard bench for ref_force_wb_arbiter
module tb_ref_force_wb_arbiter;

  localparam int DW  = 32;
  localparam int IDW = 29;
  localparam int NA  = 7;

  typedef struct packed {
    logic [2:0]     lane;
    logic [IDW-1:0] id;
    logic [DW-1:0]  fx;
    logic [DW-1:0]  fy;
    logic [DW-1:0]  fz;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NA-1:0]     in_valid;
  logic [NA-1:0]     in_start_wb;
  logic [NA*IDW-1:0] in_id;
  logic [NA*DW-1:0]  in_force_x;
  logic [NA*DW-1:0]  in_force_y;
  logic [NA*DW-1:0]  in_force_z;
  logic              out_wb_valid;
  logic              out_wb_ready;
  logic [2:0]        out_wb_lane;
  logic [IDW-1:0]    out_wb_id;
  logic [DW-1:0]     out_wb_force_x;
  logic [DW-1:0]     out_wb_force_y;
  logic [DW-1:0]     out_wb_force_z;
  logic              out_wb_done;
  logic [NA-1:0]     out_overflow;

  ref_force_wb_arbiter dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_start_wb    (in_start_wb),
    .in_id          (in_id),
    .in_force_x     (in_force_x),
    .in_force_y     (in_force_y),
    .in_force_z     (in_force_z),
    .out_wb_valid   (out_wb_valid),
    .out_wb_ready   (out_wb_ready),
    .out_wb_lane    (out_wb_lane),
    .out_wb_id      (out_wb_id),
    .out_wb_force_x (out_wb_force_x),
    .out_wb_force_y (out_wb_force_y),
    .out_wb_force_z (out_wb_force_z),
    .out_wb_done    (out_wb_done),
    .out_overflow   (out_overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  word_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    done_cnt = 0;
  int    done_cyc = 0;
  int    last_hs_cyc = 0;
  word_t cur_w;
  word_t prev_w;
  word_t exp_w;
  logic  prev_hold = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t mk(input int lane, input int tag);
    word_t w;
    w.lane = 3'(lane);
    w.id   = IDW'(tag*256 + lane*17 + 5);
    w.fx   = 32'h3F800000 ^ 32'(tag << 8) ^ 32'(lane);
    w.fy   = 32'hC0000000 + 32'(tag*7 + lane);
    w.fz   = (tag % 3 == 0) ? 32'h0 : 32'h40490FDB + 32'(lane);
    return w;
  endfunction

  task automatic drive_lane(input int lane, input word_t w);
    in_id[lane*IDW +: IDW]     = w.id;
    in_force_x[lane*DW +: DW]  = w.fx;
    in_force_y[lane*DW +: DW]  = w.fy;
    in_force_z[lane*DW +: DW]  = w.fz;
  endtask

  task automatic push_mask(input logic [NA-1:0] mask, input int tag);
    for (int i = 0; i < NA; i++) if (mask[i]) drive_lane(i, mk(i, tag));
    in_valid = mask;
    @(posedge clk);
    #1 in_valid = '0;
  endtask

  task automatic expect_lanes(input int lanes[$], input int tag);
    foreach (lanes[k]) sb.push_back(mk(lanes[k], tag));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || out_wb_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: hold stability, scoreboard pops on handshake, done pulse timing
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      cur_w = '{lane: out_wb_lane, id: out_wb_id, fx: out_wb_force_x,
                fy: out_wb_force_y, fz: out_wb_force_z};
      if (out_wb_valid && prev_hold) begin
        check("hold_lo", cur_w[63:0], prev_w[63:0]);
        check("hold_hi", cur_w[127:64], prev_w[127:64]);
      end
      if (out_wb_valid && out_wb_ready) begin
        last_hs_cyc = cyc;
        if (sb.size() == 0) begin
          check("unexpected_word", {32'h0, cur_w[127:96]}, 64'h0);
        end else begin
          exp_w = sb.pop_front();
          check("wb_lane", 64'(cur_w.lane), 64'(exp_w.lane));
          check("wb_id",   64'(cur_w.id),   64'(exp_w.id));
          check("wb_fx",   64'(cur_w.fx),   64'(exp_w.fx));
          check("wb_fy",   64'(cur_w.fy),   64'(exp_w.fy));
          check("wb_fz",   64'(cur_w.fz),   64'(exp_w.fz));
        end
      end
      if (out_wb_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_hold = out_wb_valid && !out_wb_ready;
      prev_w    = cur_w;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t w;
    rst_n        = 1'b0;
    in_valid     = '0;
    in_start_wb  = '0;
    in_id        = '0;
    in_force_x   = '0;
    in_force_y   = '0;
    in_force_z   = '0;
    out_wb_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid",    64'(out_wb_valid), 64'd0);
    check("rst_done",     64'(out_wb_done),  64'd0);
    check("rst_overflow", 64'(out_overflow), 64'd0);
    check("rst_id",       64'(out_wb_id),    64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All lanes at once from rr_ptr=0: lanes 0..6
    out_wb_ready = 1'b1;
    expect_lanes('{0, 1, 2, 3, 4, 5, 6}, 1);
    push_mask(7'h7F, 1);
    drain("rr_first_drain");

    // Single push on lane 3: valid two edges after the push, for one cycle
    w = '{lane: 3'd3, id: 29'h1A000005, fx: 32'h3F800000, fy: 32'h0, fz: 32'hBF000000};
    sb.push_back(w);
    drive_lane(3, w);
    in_valid = 7'h08;
    @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    check("lat_edge_t",   64'(out_wb_valid), 64'd0);
    @(negedge clk);
    check("lat_edge_t1",  64'(out_wb_valid), 64'd1);
    check("lat_lane",     64'(out_wb_lane),  64'd3);
    @(negedge clk);
    check("single_valid", 64'(out_wb_valid), 64'd0);
    drain("single_drain");

    // All lanes again, rr_ptr now 4
    expect_lanes('{4, 5, 6, 0, 1, 2, 3}, 3);
    push_mask(7'h7F, 3);
    drain("rr_second_drain");

    // Lane 1 filled under backpressure, then push while popping the full FIFO
    out_wb_ready = 1'b0;
    for (int t = 10; t <= 15; t++) sb.push_back(mk(1, t));
    for (int t = 10; t <= 14; t++) push_mask(7'h02, t);
    @(negedge clk);
    check("full_no_ovf1", 64'(out_overflow[1]), 64'd0);
    check("held_valid",   64'(out_wb_valid),    64'd1);
    check("held_lane",    64'(out_wb_lane),     64'd1);
    @(posedge clk);
    #1 out_wb_ready = 1'b1;
    push_mask(7'h02, 15);
    drain("pushpop_drain");
    check("pushpop_no_ovf1", 64'(out_overflow[1]), 64'd0);

    // Lane 0 overflow: one held + four queued fit, the sixth is dropped
    out_wb_ready = 1'b0;
    for (int t = 20; t <= 24; t++) sb.push_back(mk(0, t));
    for (int t = 20; t <= 24; t++) push_mask(7'h01, t);
    @(negedge clk);
    check("pre_ovf0", 64'(out_overflow[0]), 64'd0);
    @(posedge clk);
    #1;
    push_mask(7'h01, 25);
    @(negedge clk);
    check("ovf0_set", 64'(out_overflow), 64'h01);
    repeat (3) @(posedge clk);
    #1 out_wb_ready = 1'b1;
    drain("ovf_drain");
    check("no_done_yet", 64'(done_cnt), 64'd0);

    // Writeback round: start edge with three pushes, rr_ptr now 1
    expect_lanes('{1, 2, 0}, 30);
    in_start_wb = 7'h07;
    push_mask(7'h07, 30);
    drain("done_drain");
    repeat (4) @(negedge clk);
    check("done_once",   64'(done_cnt), 64'd1);
    check("done_timing", 64'(done_cyc - last_hs_cyc), 64'd2);
    repeat (20) @(posedge clk);
    in_start_wb = '0;
    repeat (10) @(posedge clk);
    check("done_no_repeat", 64'(done_cnt), 64'd1);
    #1;

    // Reset in the middle of a held transfer
    out_wb_ready = 1'b0;
    push_mask(7'h05, 40);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_valid",    64'(out_wb_valid),   64'd0);
    check("midrst_overflow", 64'(out_overflow),   64'd0);
    check("midrst_id",       64'(out_wb_id),      64'd0);
    check("midrst_fx",       64'(out_wb_force_x), 64'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    out_wb_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_stale_word", 64'(out_wb_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
